periph_bus_arbiter: RTL and testbench

Two-master arbiter for the memory-mapped peripheral bus (timer TH/TL/TCON, LEDs, 7-seg `digi`, systick at 0x4000_0000–0x4000_0014). Sits between the CPU data port (master 0) and a secondary agent such as a UART or DMA (master 1) on one side, and the single peripheral slave on the other. It serialises accesses with round-robin fairness and an optional bus lock for multi-register programming sequences. It returns registered read data and a one-cycle acknowledge.

---
 rtl/periph_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master arbiter in front of the memory-mapped peripheral slave.
// Serialises accesses with round-robin fairness. Each transaction takes IDLE -> ACCESS -> RESP,
// so the slave strobe follows the sampled request by one cycle and the ack by two.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   - a transaction completed with lock=1 makes its master the lock owner; while locked
//               only the owner is eligible. The owner releases by completing a lock=0 transaction.
//   undefined - m0_lock/m1_lock are ignored, no lock state exists, pure round-robin.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mX_req/rd/wr/lock     master X command, held stable until mX_ack
//   mX_addr/wdata         master X byte address and write data
//   mX_ack                one-cycle completion pulse (RESP)
//   mX_rdata              read data while mX_ack is high, otherwise 0
//   s_rd/s_wr             slave strobes (ACCESS only, write wins over read)
//   s_addr/s_wdata        slave address/write data (ACCESS only, otherwise 0)
//   s_rdata               combinational slave read data
//   busy                  high whenever the arbiter is not idle
module periph_bus_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_rd,
   input  logic              m0_wr,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_rd,
   input  logic              m1_wr,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_rd,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                r_last_gnt, w_last_gnt_nxt;
   logic                r_cmd_id, w_cmd_id_nxt;
   logic                r_cmd_rd, w_cmd_rd_nxt;
   logic                r_cmd_wr, w_cmd_wr_nxt;
   logic                r_s_rd, w_s_rd_nxt;
   logic                r_s_wr, w_s_wr_nxt;
   logic [ADDR_W-1:0]   r_s_addr, w_s_addr_nxt;
   logic [DATA_W-1:0]   r_s_wdata, w_s_wdata_nxt;
   logic                r_m0_ack, w_m0_ack_nxt;
   logic                r_m1_ack, w_m1_ack_nxt;
   logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
   logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;
   logic                r_busy, w_busy_nxt;
   logic                w_elig0, w_elig1, w_win, w_rd_eff;

`ifdef ARB_LOCK_EN
   logic                r_cmd_lock, w_cmd_lock_nxt;
   logic                r_lock_vld, w_lock_vld_nxt;
   logic                r_lock_own, w_lock_own_nxt;

   // While a lock is held only its owner may win.
   assign w_elig0 = m0_req & (~r_lock_vld | ~r_lock_own);
   assign w_elig1 = m1_req & (~r_lock_vld |  r_lock_own);
`else
   logic                w_unused_lock;

   assign w_unused_lock = m0_lock ^ m1_lock;
   assign w_elig0       = m0_req;
   assign w_elig1       = m1_req;
`endif

   // On a tie the master not served last wins.
   assign w_win    = (w_elig0 & w_elig1) ? ~r_last_gnt : w_elig1;
   assign w_rd_eff = r_cmd_rd & ~r_cmd_wr;

   // Next-state and next-output logic; outputs default to 0 outside their phase.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      w_cmd_id_nxt   = r_cmd_id;
      w_cmd_rd_nxt   = r_cmd_rd;
      w_cmd_wr_nxt   = r_cmd_wr;
      w_s_rd_nxt     = 1'b0;
      w_s_wr_nxt     = 1'b0;
      w_s_addr_nxt   = '0;
      w_s_wdata_nxt  = '0;
      w_m0_ack_nxt   = 1'b0;
      w_m1_ack_nxt   = 1'b0;
      w_m0_rdata_nxt = '0;
      w_m1_rdata_nxt = '0;
      w_busy_nxt     = 1'b0;
`ifdef ARB_LOCK_EN
      w_cmd_lock_nxt = r_cmd_lock;
      w_lock_vld_nxt = r_lock_vld;
      w_lock_own_nxt = r_lock_own;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_elig0 | w_elig1) begin
               w_state_nxt    = ST_ACCESS;
               w_last_gnt_nxt = w_win;
               w_cmd_id_nxt   = w_win;
               w_cmd_rd_nxt   = w_win ? m1_rd : m0_rd;
               w_cmd_wr_nxt   = w_win ? m1_wr : m0_wr;
               // Strobes and address are registered here so they appear during ACCESS.
               w_s_rd_nxt     = w_cmd_rd_nxt & ~w_cmd_wr_nxt;
               w_s_wr_nxt     = w_cmd_wr_nxt;
               w_s_addr_nxt   = w_win ? m1_addr : m0_addr;
               w_s_wdata_nxt  = w_win ? m1_wdata : m0_wdata;
               w_busy_nxt     = 1'b1;
`ifdef ARB_LOCK_EN
               w_cmd_lock_nxt = w_win ? m1_lock : m0_lock;
`endif
            end
         end
         ST_ACCESS: begin
            w_state_nxt  = ST_RESP;
            w_busy_nxt   = 1'b1;
            w_m0_ack_nxt = ~r_cmd_id;
            w_m1_ack_nxt = r_cmd_id;
            // Read register: slave data only for an effective read, routed to the owner.
            if (w_rd_eff) begin
               if (r_cmd_id) begin
                  w_m1_rdata_nxt = s_rdata;
               end else begin
                  w_m0_rdata_nxt = s_rdata;
               end
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
`ifdef ARB_LOCK_EN
            // Only the owner can complete while locked, so the lock simply follows this command.
            w_lock_vld_nxt = r_cmd_lock;
            w_lock_own_nxt = r_cmd_id;
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, command and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
         r_cmd_id   <= 1'b0;
         r_cmd_rd   <= 1'b0;
         r_cmd_wr   <= 1'b0;
         r_s_rd     <= 1'b0;
         r_s_wr     <= 1'b0;
         r_s_addr   <= '0;
         r_s_wdata  <= '0;
         r_m0_ack   <= 1'b0;
         r_m1_ack   <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
         r_busy     <= 1'b0;
`ifdef ARB_LOCK_EN
         r_cmd_lock <= 1'b0;
         r_lock_vld <= 1'b0;
         r_lock_own <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         r_cmd_id   <= w_cmd_id_nxt;
         r_cmd_rd   <= w_cmd_rd_nxt;
         r_cmd_wr   <= w_cmd_wr_nxt;
         r_s_rd     <= w_s_rd_nxt;
         r_s_wr     <= w_s_wr_nxt;
         r_s_addr   <= w_s_addr_nxt;
         r_s_wdata  <= w_s_wdata_nxt;
         r_m0_ack   <= w_m0_ack_nxt;
         r_m1_ack   <= w_m1_ack_nxt;
         r_m0_rdata <= w_m0_rdata_nxt;
         r_m1_rdata <= w_m1_rdata_nxt;
         r_busy     <= w_busy_nxt;
`ifdef ARB_LOCK_EN
         r_cmd_lock <= w_cmd_lock_nxt;
         r_lock_vld <= w_lock_vld_nxt;
         r_lock_own <= w_lock_own_nxt;
`endif
      end
   end

   assign s_rd     = r_s_rd;
   assign s_wr     = r_s_wr;
   assign s_addr   = r_s_addr;
   assign s_wdata  = r_s_wdata;
   assign m0_ack   = r_m0_ack;
   assign m1_ack   = r_m1_ack;
   assign m0_rdata = r_m0_rdata;
   assign m1_rdata = r_m1_rdata;
   assign busy     = r_busy;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant at cycle n -> strobe n+1, ack n+2, free n+3).
// Lock expectations follow the ARB_LOCK_EN macro.
module tb_periph_bus_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_req, m0_rd, m0_wr, m0_lock, m0_ack;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_req, m1_rd, m1_wr, m1_lock, m1_ack;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic              s_rd, s_wr, busy;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata, s_rdata;

   int checks   = 0;
   int failures = 0;

   periph_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Slave: 8 words at 0x4000_0000, combinational read, write on the clock edge.
   logic [31:0] slave_mem [0:7];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_idx = 3'd0;
   logic [31:0] pl_val = 32'd0;

   assign s_rdata = slave_mem[s_addr[4:2]];

   always @(posedge clk) begin
      if (s_wr) slave_mem[s_addr[4:2]] <= s_wdata;
      else if (pl_en) slave_mem[pl_idx] <= pl_val;
   end

   task automatic set_idle();
      m0_req = 0; m0_rd = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_rd = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic drive(input int m, input logic rd, input logic wr, input logic lk,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (m == 0) begin
         m0_req = 1; m0_rd = rd; m0_wr = wr; m0_lock = lk; m0_addr = addr; m0_wdata = wd;
      end else begin
         m1_req = 1; m1_rd = rd; m1_wr = wr; m1_lock = lk; m1_addr = addr; m1_wdata = wd;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_idle();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic preload(input logic [2:0] idx, input logic [31:0] val);
      pl_idx = idx; pl_val = val; pl_en = 1'b1;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_idle();
      @(posedge clk); #1;
      drive(0, 1, 0, 0, 32'h4000_0000, 32'h0);
      drive(1, 0, 1, 0, 32'h4000_0004, 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_rd, s_wr, m0_ack, m1_ack, busy} !== 5'b0) begin
         failures++; $display("FAIL reset_ctl got=%b exp=00000", {s_rd, s_wr, m0_ack, m1_ack, busy});
      end
      checks++;
      if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {s_addr, s_wdata, m0_rdata, m1_rdata});
      end
      set_idle();
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL idle_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      drive(0, 0, 1, 0, 32'h4000_000C, 32'h0000_00A5);
      @(negedge clk);
      checks++;
      if ({s_wr, busy} !== 2'b00) begin
         failures++; $display("FAIL wr_c0 got=%b exp=00", {s_wr, busy});
      end
      @(negedge clk);
      checks++;
      if ({s_wr, s_rd, busy, s_addr, s_wdata} !== {3'b101, 32'h4000_000C, 32'h0000_00A5}) begin
         failures++; $display("FAIL wr_strobe got=%b/%h/%h exp=101/4000000c/000000a5",
                              {s_wr, s_rd, busy}, s_addr, s_wdata);
      end
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, s_wr, m0_rdata} !== {3'b100, 32'h0}) begin
         failures++; $display("FAIL wr_ack got=%b/%h exp=100/0", {m0_ack, m1_ack, s_wr}, m0_rdata);
      end
      @(posedge clk); #1 set_idle();
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, busy} !== 3'b000) begin
         failures++; $display("FAIL wr_after got=%b exp=000", {m0_ack, m1_ack, busy});
      end
      checks++;
      if (slave_mem[3] !== 32'h0000_00A5) begin
         failures++; $display("FAIL wr_commit got=%h exp=000000a5", slave_mem[3]);
      end
   endtask

   task automatic test_single_read();
      int n_rd;
      do_reset();
      preload(3'd5, 32'h0000_1234);
      drive(1, 1, 0, 0, 32'h4000_0014, 32'h0);
      n_rd = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (s_rd === 1'b1) n_rd++;
         if (k == 2) begin
            checks++;
            if ({m1_ack, m0_ack, m1_rdata} !== {2'b10, 32'h0000_1234}) begin
               failures++; $display("FAIL rd_ack got=%b/%h exp=10/00001234", {m1_ack, m0_ack}, m1_rdata);
            end
            @(posedge clk); #1 set_idle();
         end
         if (k == 3) begin
            checks++;
            if ({m1_ack, m1_rdata} !== {1'b0, 32'h0}) begin
               failures++; $display("FAIL rd_after got=%b/%h exp=0/0", m1_ack, m1_rdata);
            end
         end
      end
      checks++;
      if (n_rd != 1) begin
         failures++; $display("FAIL rd_pulses got=%0d exp=1", n_rd);
      end
   endtask

   task automatic test_contention();
      int ack_id[$];
      int ack_at[$];
      do_reset();
      drive(0, 1, 0, 0, 32'h4000_0000, 32'h0);
      drive(1, 1, 0, 0, 32'h4000_0004, 32'h0);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         checks++;
         if ((m0_ack & m1_ack) !== 1'b0) begin
            failures++; $display("FAIL cont_both_ack cycle=%0d got=%b%b exp=not both", c, m0_ack, m1_ack);
         end
         if (m0_ack === 1'b1) begin ack_id.push_back(0); ack_at.push_back(c); end
         if (m1_ack === 1'b1) begin ack_id.push_back(1); ack_at.push_back(c); end
      end
      @(posedge clk); #1 set_idle();
      checks++;
      if (ack_id.size() < 4) begin
         failures++; $display("FAIL cont_count got=%0d exp>=4", ack_id.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_id[i] != (i % 2) || ack_at[i] != 2 + 3 * i) begin
               failures++; $display("FAIL cont_order idx=%0d got=m%0d@%0d exp=m%0d@%0d",
                                    i, ack_id[i], ack_at[i], i % 2, 2 + 3 * i);
            end
         end
      end
   endtask

   task automatic test_lock();
      logic [31:0] l_addr [3];
      logic [31:0] l_data [3];
      logic        l_lock [3];
      int          exp_ids [4];
      int          ack_id[$];
      int          idx;
      logic        m1_done;
      l_addr[0] = 32'h4000_0000; l_data[0] = 32'h12; l_lock[0] = 1'b1;
      l_addr[1] = 32'h4000_0004; l_data[1] = 32'h34; l_lock[1] = 1'b1;
      l_addr[2] = 32'h4000_0008; l_data[2] = 32'h03; l_lock[2] = 1'b0;
`ifdef ARB_LOCK_EN
      exp_ids[0] = 1; exp_ids[1] = 1; exp_ids[2] = 1; exp_ids[3] = 0;
`else
      exp_ids[0] = 1; exp_ids[1] = 0; exp_ids[2] = 1; exp_ids[3] = 0;
`endif
      do_reset();
      idx = 0;
      m1_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c == 0) drive(1, 0, 1, l_lock[0], l_addr[0], l_data[0]);
         if (c == 1) drive(0, 1, 0, 0, 32'h4000_0010, 32'h0);
         if (m1_done) begin
            idx++;
            if (idx < 3) drive(1, 0, 1, l_lock[idx], l_addr[idx], l_data[idx]);
            else begin m1_req = 0; m1_wr = 0; m1_lock = 0; end
         end
         @(negedge clk);
         m1_done = (m1_ack === 1'b1);
         if (m0_ack === 1'b1) ack_id.push_back(0);
         if (m1_ack === 1'b1) ack_id.push_back(1);
         @(posedge clk); #1;
      end
      set_idle();
      checks++;
      if (ack_id.size() < 4) begin
         failures++; $display("FAIL lock_count got=%0d exp>=4", ack_id.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_id[i] != exp_ids[i]) begin
               failures++; $display("FAIL lock_order idx=%0d got=m%0d exp=m%0d", i, ack_id[i], exp_ids[i]);
            end
         end
      end
      checks++;
      if ({slave_mem[0], slave_mem[1], slave_mem[2]} !== {32'h12, 32'h34, 32'h03}) begin
         failures++; $display("FAIL lock_data got=%h/%h/%h exp=12/34/3", slave_mem[0], slave_mem[1], slave_mem[2]);
      end
   endtask

   task automatic test_rdwr();
      do_reset();
      preload(3'd4, 32'hDEAD_BEEF);
      drive(0, 1, 1, 0, 32'h4000_0010, 32'h0000_0055);
      repeat (2) @(negedge clk);
      checks++;
      if ({s_wr, s_rd, s_addr} !== {2'b10, 32'h4000_0010}) begin
         failures++; $display("FAIL rdwr_strobe got=%b/%h exp=10/40000010", {s_wr, s_rd}, s_addr);
      end
      @(negedge clk);
      checks++;
      if ({m0_ack, m0_rdata} !== {1'b1, 32'h0}) begin
         failures++; $display("FAIL rdwr_ack got=%b/%h exp=1/0", m0_ack, m0_rdata);
      end
      @(posedge clk); #1 set_idle();
      checks++;
      if (slave_mem[4] !== 32'h0000_0055) begin
         failures++; $display("FAIL rdwr_commit got=%h exp=00000055", slave_mem[4]);
      end
   endtask

   task automatic test_reset_mid();
      int n_ack;
      do_reset();
      drive(0, 0, 1, 0, 32'h4000_0008, 32'h0000_0077);
      repeat (2) @(negedge clk);
      checks++;
      if (s_wr !== 1'b1) begin
         failures++; $display("FAIL mid_strobe got=%b exp=1", s_wr);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, busy, s_wr, s_rd} !== 5'b0) begin
         failures++; $display("FAIL mid_abort got=%b exp=00000", {m0_ack, m1_ack, busy, s_wr, s_rd});
      end
      checks++;
      if (slave_mem[2] !== 32'h0000_0077) begin
         failures++; $display("FAIL mid_write_kept got=%h exp=00000077", slave_mem[2]);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      set_idle();
      drive(0, 1, 0, 0, 32'h4000_0000, 32'h0);
      drive(1, 1, 0, 0, 32'h4000_0004, 32'h0);
      n_ack = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k < 2 && (m0_ack | m1_ack) === 1'b1) n_ack++;
      end
      checks++;
      if ({m0_ack, m1_ack} !== 2'b10 || n_ack != 0) begin
         failures++; $display("FAIL mid_tie got=%b early=%0d exp=10 early=0", {m0_ack, m1_ack}, n_ack);
      end
      @(posedge clk); #1 set_idle();
   endtask

   task automatic test_random();
      logic [31:0] ref_mem [0:7];
      logic        act [2];
      int          gap [2];
      logic        done [2];
      logic        c_rd [2];
      logic        c_wr [2];
      logic        c_lk [2];
      logic [2:0]  c_idx [2];
      logic [31:0] c_wd [2];
      int          free_at, strobe_cyc, ack_cyc, last, w;
      logic        lock_vld, el0, el1, e_rd_eff, e_wr;
      int          lock_own, e_id;
      logic [31:0] e_addr, e_wd, e_rdata, v, e_a, e_w, e_r0, e_r1;
      logic [4:0]  e_ctl;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         v = $urandom;
         preload(3'(i), v);
         ref_mem[i] = v;
      end
      for (int m = 0; m < 2; m++) begin
         act[m] = 0; gap[m] = 0; done[m] = 0;
         c_rd[m] = 0; c_wr[m] = 0; c_lk[m] = 0; c_idx[m] = 0; c_wd[m] = 0;
      end
      free_at = 0; strobe_cyc = -1; ack_cyc = -1; last = 1; lock_vld = 0; lock_own = 0;
      e_id = 0; e_rd_eff = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_rdata = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (done[m]) begin act[m] = 0; done[m] = 0; gap[m] = $urandom_range(0, 2); end
            if (!act[m]) begin
               if (gap[m] == 0) begin
                  act[m] = 1;
                  c_rd[m] = 1'($urandom_range(0, 1));
                  c_wr[m] = 1'($urandom_range(0, 1));
                  c_lk[m] = ($urandom_range(0, 3) == 0);
                  c_idx[m] = 3'($urandom_range(0, 5));
                  c_wd[m] = $urandom;
               end else gap[m]--;
            end
         end
         m0_req = act[0]; m0_rd = c_rd[0]; m0_wr = c_wr[0]; m0_lock = c_lk[0];
         m0_addr = 32'h4000_0000 | (32'(c_idx[0]) << 2); m0_wdata = c_wd[0];
         m1_req = act[1]; m1_rd = c_rd[1]; m1_wr = c_wr[1]; m1_lock = c_lk[1];
         m1_addr = 32'h4000_0000 | (32'(c_idx[1]) << 2); m1_wdata = c_wd[1];
         @(negedge clk);
         e_ctl = 5'b0; e_a = 0; e_w = 0; e_r0 = 0; e_r1 = 0;
         if (cyc == strobe_cyc) begin
            e_ctl = {e_rd_eff, e_wr, 2'b00, 1'b1}; e_a = e_addr; e_w = e_wd;
         end else if (cyc == ack_cyc) begin
            e_ctl = {2'b00, e_id == 0, e_id == 1, 1'b1};
            if (e_id == 0) e_r0 = e_rdata; else e_r1 = e_rdata;
         end
         checks++;
         if ({s_rd, s_wr, m0_ack, m1_ack, busy} !== e_ctl) begin
            failures++; $display("FAIL rnd_ctl cycle=%0d got=%b exp=%b", cyc, {s_rd, s_wr, m0_ack, m1_ack, busy}, e_ctl);
         end
         checks++;
         if ({s_addr, s_wdata} !== {e_a, e_w}) begin
            failures++; $display("FAIL rnd_bus cycle=%0d got=%h/%h exp=%h/%h", cyc, s_addr, s_wdata, e_a, e_w);
         end
         checks++;
         if ({m0_rdata, m1_rdata} !== {e_r0, e_r1}) begin
            failures++; $display("FAIL rnd_rdata cycle=%0d got=%h/%h exp=%h/%h", cyc, m0_rdata, m1_rdata, e_r0, e_r1);
         end
         if (cyc == ack_cyc) done[e_id] = 1;
         if (cyc >= free_at) begin
            el0 = act[0]; el1 = act[1];
`ifdef ARB_LOCK_EN
            if (lock_vld) begin el0 = el0 && (lock_own == 0); el1 = el1 && (lock_own == 1); end
`endif
            if (el0 || el1) begin
               w = (el0 && el1) ? 1 - last : (el1 ? 1 : 0);
               e_id = w;
               e_rd_eff = c_rd[w] & ~c_wr[w];
               e_wr = c_wr[w];
               e_addr = 32'h4000_0000 | (32'(c_idx[w]) << 2);
               e_wd = c_wd[w];
               e_rdata = e_rd_eff ? ref_mem[c_idx[w]] : 32'h0;
               if (c_wr[w]) ref_mem[c_idx[w]] = c_wd[w];
               last = w;
               lock_vld = c_lk[w];
               lock_own = w;
               strobe_cyc = cyc + 1; ack_cyc = cyc + 2; free_at = cyc + 3;
            end
         end
         @(posedge clk); #1;
      end
      set_idle();
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_lock();
      test_rdwr();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
